// File: rtl/enh_demux.sv
//------------------------------------------------------------------------------
// enh_demux : routes valid flits to one of two ports, each with its own FIFO
//             and registered output stage; sticky err flags any dropped flit.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enh_demux_port #(
  parameter int WIDTH    = 17,
  parameter int VAL_BIT  = 1,
  parameter int ADDR_W   = 2,
  parameter bit PORT_SEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             stall,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             drop
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              hit, push, pop, free;

  assign hit  = in[WIDTH-1] && (in[WIDTH-1-VAL_BIT] == PORT_SEL);
  // full comes purely from the registered count, so a pop this cycle never
  // makes room for an incoming flit.
  assign full = (count_q == DEPTH);
  assign push = hit && !full;
  assign drop = hit && full;
  assign free = !out_q[WIDTH-1] || !stall;
  assign pop  = free && (count_q != '0);

  assign wptr_d  = wptr_q + ADDR_W'(push);
  assign rptr_d  = rptr_q + ADDR_W'(pop);
  assign count_d = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

  always_comb begin
    out_d = out_q;
    if (free) begin
      out_d = pop ? mem_q[rptr_q] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

module enh_demux #(
  parameter int word_width     = 17,
  parameter int val_bit        = 1,
  parameter int log_buffer_len = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] in,
  input  logic                  stall_1,
  input  logic                  stall_2,
  output logic [word_width-1:0] out_1,
  output logic [word_width-1:0] out_2,
  output logic                  full_1,
  output logic                  full_2,
  output logic                  err
);

  logic drop_1, drop_2;
  logic err_q, err_d;

  enh_demux_port #(
    .WIDTH    (word_width),
    .VAL_BIT  (val_bit),
    .ADDR_W   (log_buffer_len),
    .PORT_SEL (1'b0)
  ) u_port_1 (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .stall (stall_1),
    .out   (out_1),
    .full  (full_1),
    .drop  (drop_1)
  );

  enh_demux_port #(
    .WIDTH    (word_width),
    .VAL_BIT  (val_bit),
    .ADDR_W   (log_buffer_len),
    .PORT_SEL (1'b1)
  ) u_port_2 (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .stall (stall_2),
    .out   (out_2),
    .full  (full_2),
    .drop  (drop_2)
  );

  assign err_d = err_q | drop_1 | drop_2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_enh_demux.sv
// Self-checking bench for enh_demux: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
`default_nettype none

module tb_enh_demux;

  localparam int W     = 17;
  localparam int VB    = 1;
  localparam int LB    = 2;
  localparam int DEPTH = 1 << LB;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         s1, s2;
  logic [W-1:0] out_1, out_2;
  logic         full_1, full_2, err;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per port plus the word currently presented.
  logic [W-1:0] mq [2][$];
  logic [W-1:0] m_out [2];
  logic         m_err;

  enh_demux #(
    .word_width     (W),
    .val_bit        (VB),
    .log_buffer_len (LB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (din),
    .stall_1 (s1),
    .stall_2 (s2),
    .out_1   (out_1),
    .out_2   (out_2),
    .full_1  (full_1),
    .full_2  (full_2),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq[0].delete();
    mq[1].delete();
    m_out[0] = '0;
    m_out[1] = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] d, input logic st1, input logic st2);
    for (int p = 0; p < 2; p++) begin
      logic stall;
      logic was_full;
      stall    = (p == 0) ? st1 : st2;
      was_full = (mq[p].size() == DEPTH);
      if (!m_out[p][W-1] || !stall) begin
        m_out[p] = (mq[p].size() > 0) ? mq[p].pop_front() : '0;
      end
      if (d[W-1] && (int'(d[W-1-VB]) == p)) begin
        if (was_full) m_err = 1'b1;
        else          mq[p].push_back(d);
      end
    end
  endtask

  task automatic check_all();
    check("out_1",  out_1, m_out[0]);
    check("out_2",  out_2, m_out[1]);
    check("full_1", W'(full_1), W'(mq[0].size() == DEPTH));
    check("full_2", W'(full_2), W'(mq[1].size() == DEPTH));
    check("err",    W'(err), W'(m_err));
  endtask

  task automatic cycle(input logic [W-1:0] d, input logic st1, input logic st2);
    din = d;
    s1  = st1;
    s2  = st2;
    @(posedge clk);
    model_step(d, st1, st2);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int          stall_pct;

    rst = 1'b0;
    din = '0;
    s1  = 1'b0;
    s2  = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // Idle: invalid flits only
    for (int i = 0; i < 17; i++) cycle(17'h0000F, 1'b0, 1'b0);

    // Routing to each port
    cycle(17'h10123, 1'b0, 1'b0);
    cycle(17'h1808F, 1'b0, 1'b0);
    check("route_out_1", out_1, 17'h10123);
    cycle(17'h0000F, 1'b0, 1'b0);
    check("route_out_2", out_2, 17'h1808F);
    for (int i = 0; i < 3; i++) cycle(17'h0000F, 1'b0, 1'b0);

    // Overflow on port 1, then drain
    for (int i = 0; i < 6; i++) cycle(17'h10123, 1'b1, 1'b0);
    check("ovf_full_1", W'(full_1), W'(1'b1));
    check("ovf_err",    W'(err),    W'(1'b1));
    for (int i = 0; i < 8; i++) cycle(17'h0000F, 1'b0, 1'b0);

    // Independence: port 2 full and stalled, port 1 flows
    for (int i = 0; i < 6; i++) cycle(17'h1B0B0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle((i % 2 == 0) ? 17'h1B0B0 : 17'h10A0A, 1'b0, 1'b1);
      check("indep_full_1", W'(full_1), W'(1'b0));
    end
    for (int i = 0; i < 8; i++) cycle(17'h0000F, 1'b0, 1'b0);

    // Simultaneous push/pop on a full port-1 FIFO
    for (int i = 0; i < 5; i++) cycle(17'h10001, 1'b1, 1'b0);
    cycle(17'h10001, 1'b0, 1'b0);
    check("pp_full_1", W'(full_1), W'(1'b0));
    for (int i = 0; i < 6; i++) cycle(17'h0000F, 1'b0, 1'b0);

    // Reset with both FIFOs loaded
    for (int i = 0; i < 4; i++) cycle((i % 2 == 0) ? 17'h10123 : 17'h1808F, 1'b1, 1'b1);
    async_reset();
    cycle(17'h1AAAA, 1'b0, 1'b0);
    cycle(17'h0000F, 1'b0, 1'b0);
    check("rst_out_2", out_2, 17'h1AAAA);
    check("rst_err",   W'(err), W'(1'b0));

    // Random traffic with varying stall pressure
    for (int blk = 0; blk < 10; blk++) begin
      stall_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 85);
      for (int i = 0; i < 200; i++) begin
        r = $urandom;
        cycle(r[W-1:0],
              ($urandom_range(0, 99) < stall_pct),
              ($urandom_range(0, 99) < stall_pct));
      end
      if (blk == 4) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/enh_demux.md
ENH_DEMUX -- requirements
Module: enh_demux

Interface
REQ-001 The module SHALL have parameter word_width, default 17, meaning total flit width in bits.
REQ-002 The module SHALL have parameter val_bit, default 1, meaning width of the valid field at the top of the word.
REQ-003 The module SHALL have parameter log_buffer_len, default 2, meaning log2 of the per-output FIFO depth (default depth 4).
REQ-004 clk  input  1  meaning single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  meaning asynchronous, active-low reset.
REQ-006 in  input  word_width  meaning incoming flit; valid = in[word_width-1], destination = in[word_width-1-val_bit] (0 -> port 1, 1 -> port 2).
REQ-007 stall_1  input  1  meaning downstream on port 1 cannot take a flit this cycle.
REQ-008 stall_2  input  1  meaning downstream on port 2 cannot take a flit this cycle.
REQ-009 out_1  output  word_width  meaning registered flit toward port 1; all zeros when idle.
REQ-010 out_2  output  word_width  meaning registered flit toward port 2; all zeros when idle.
REQ-011 full_1  output  1  meaning port-1 FIFO holds 2^log_buffer_len words.
REQ-012 full_2  output  1  meaning port-2 FIFO holds 2^log_buffer_len words.
REQ-013 err  output  1  meaning sticky flag: a valid flit was dropped.

Function
REQ-014 Invalid flits (valid bit 0) SHALL be ignored: no FIFO write, no state change.
REQ-015 A valid flit SHALL be written, unmodified (all word_width bits), into the FIFO of its destination at the sampling edge if that FIFO's full flag is 0 before the edge.
REQ-016 A valid flit whose destination FIFO is full SHALL be discarded and err SHALL be set at that edge; a pop in the same cycle SHALL NOT make room for it.
REQ-017 Each port SHALL have an independent circular FIFO, depth 2^log_buffer_len, with read/write pointers of log_buffer_len bits that wrap modulo depth and a count of log_buffer_len+1 bits.
REQ-018 full_d SHALL equal (count_d == depth), derived from registered state only, with no combinational path from in or stall_d.
REQ-019 The out_d register is "consumed" at an edge when its valid bit is 1 and stall_d is 0.
REQ-020 At each edge, if out_d is empty or consumed, out_d SHALL load the FIFO head (popping it) when count_d > 0, else load all zeros.
REQ-021 If out_d is valid and stall_d is 1, out_d and its FIFO read side SHALL hold.
REQ-022 Latency: flit sampled at edge k SHALL appear on out_d after edge k+1 when its FIFO was empty and out_d was free.
REQ-023 A simultaneous write and pop on the same FIFO SHALL leave count unchanged and both pointers advanced.
REQ-024 Flit order within each port SHALL be preserved; the two ports SHALL operate independently (stall on one never blocks the other).
REQ-025 Back-to-back valid flits SHALL be accepted one per cycle, sustaining full throughput when stall_d is 0.

Reset
REQ-026 While rst is 0, out_1 and out_2 SHALL be all zeros, counts and pointers 0, full_1/full_2 0, err 0, asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight flits; after release the first valid flit SHALL follow REQ-022.
REQ-028 err SHALL be cleared only by reset.

Verification
REQ-029 Idle: in=17'h0000F for 17 cycles after reset -> out_1=out_2=0, full_1=full_2=0, err=0.
REQ-030 Routing: in=17'h10123 one cycle, then 17'h1808F one cycle, stalls low -> out_1=17'h10123 one cycle after its sample edge, out_2=17'h1808F one cycle later; each visible exactly one cycle.
REQ-031 Overflow: stall_1=1, in=17'h10123 for 6 consecutive cycles -> first word held on out_1, full_1=1 after 5th edge, 6th flit dropped, err=1; release stall_1 -> exactly 5 words drain in order, then out_1=0.
REQ-032 Independence: stall_2=1 with port-2 FIFO full, alternate 17'h1B0B0 and 17'h00B0B/17'h10A0A -> port-1 flits 17'h10A0A pass at full rate, full_1 stays 0.
REQ-033 Simultaneous push/pop: full_1=1, stall_1 toggled low for one cycle while in=17'h10001 -> flit dropped (err=1), count goes 4->3, full_1 deasserts next cycle.
REQ-034 Reset mid-traffic: rst=0 while both FIFOs non-empty -> outputs 0 immediately; after release in=17'h1AAAA -> out_2=17'h1AAAA one cycle later, err=0.
